alu_8: RTL and testbench

ALU_8 -- requirements
Module: alu_8

---
 rtl/alu_8_pkg.sv | 35 +++
 rtl/alu_8_if.sv | 21 ++
 rtl/alu_8_shift.sv | 29 ++
 rtl/alu_8.sv | 117 +++++++++++
 tb/tb_alu_8.sv | 131 +++++++++++++
 5 files changed

// File: rtl/alu_8_pkg.sv
// rtl/alu_8_pkg.sv - opcode type, opcode constants and flag bit indices for alu_8 (output stage macro ALU8_OUT_REG_EN)
package alu_8_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'h00;
  localparam opcode_t OP_ADC  = 5'h01;
  localparam opcode_t OP_SUB  = 5'h02;
  localparam opcode_t OP_SBC  = 5'h03;
  localparam opcode_t OP_CP   = 5'h04;
  localparam opcode_t OP_AND  = 5'h05;
  localparam opcode_t OP_OR   = 5'h06;
  localparam opcode_t OP_XOR  = 5'h07;
  localparam opcode_t OP_RL   = 5'h08;
  localparam opcode_t OP_RR   = 5'h09;
  localparam opcode_t OP_RLA  = 5'h0A;
  localparam opcode_t OP_RRA  = 5'h0B;
  localparam opcode_t OP_RLC  = 5'h0C;
  localparam opcode_t OP_RRC  = 5'h0D;
  localparam opcode_t OP_RLCA = 5'h0E;
  localparam opcode_t OP_RRCA = 5'h0F;
  localparam opcode_t OP_SLA  = 5'h10;
  localparam opcode_t OP_SRA  = 5'h11;
  localparam opcode_t OP_SRL  = 5'h12;
  localparam opcode_t OP_SWAP = 5'h13;
  localparam opcode_t OP_BIT  = 5'h14;
  localparam opcode_t OP_RES  = 5'h15;
  localparam opcode_t OP_SET  = 5'h16;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

endpackage

// File: rtl/alu_8_if.sv
// rtl/alu_8_if.sv - operand/result bundle for alu_8 with master (driver) and slave (ALU) views
interface alu_8_if;
  import alu_8_pkg::*;

  logic [7:0] regA;
  logic [7:0] regB;
  opcode_t    opcode;
  logic [7:0] flagsIn;
  logic [7:0] res;
  logic [7:0] flagsOut;

  modport master (
    output regA, regB, opcode, flagsIn,
    input  res, flagsOut
  );

  modport slave (
    input  regA, regB, opcode, flagsIn,
    output res, flagsOut
  );
endinterface

// File: rtl/alu_8_shift.sv
// rtl/alu_8_shift.sv - shift, rotate and swap unit of alu_8; non-shift opcodes pass A through with no carry
module alu_8_shift
  import alu_8_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic       cin_i,
  input  opcode_t    opcode_i,
  output logic [7:0] result_o,
  output logic       cout_o
);

  // The accumulator variants (RLA etc.) move bits exactly like their plain forms; only Z differs, handled in the top
  always_comb begin
    result_o = a_i;
    cout_o   = 1'b0;
    case (opcode_i)
      OP_RL, OP_RLA:   begin result_o = {a_i[6:0], cin_i};    cout_o = a_i[7]; end
      OP_RR, OP_RRA:   begin result_o = {cin_i, a_i[7:1]};    cout_o = a_i[0]; end
      OP_RLC, OP_RLCA: begin result_o = {a_i[6:0], a_i[7]};   cout_o = a_i[7]; end
      OP_RRC, OP_RRCA: begin result_o = {a_i[0], a_i[7:1]};   cout_o = a_i[0]; end
      OP_SLA:          begin result_o = {a_i[6:0], 1'b0};     cout_o = a_i[7]; end
      OP_SRA:          begin result_o = {a_i[7], a_i[7:1]};   cout_o = a_i[0]; end
      OP_SRL:          begin result_o = {1'b0, a_i[7:1]};     cout_o = a_i[0]; end
      OP_SWAP:         begin result_o = {a_i[3:0], a_i[7:4]}; cout_o = 1'b0;   end
      default:         begin result_o = a_i;                  cout_o = 1'b0;   end
    endcase
  end

endmodule

// File: rtl/alu_8.sv
// rtl/alu_8.sv - 8-bit ALU with Z/N/H/C flags; ALU8_OUT_REG_EN registers res/flagsOut (1-cycle latency, sync reset)
module alu_8
  import alu_8_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  alu_8_if.slave    bus
);

  logic [7:0] res_d;
  logic [7:0] flags_d;
  logic [7:0] sh_res;
  logic       sh_c;
  logic       use_c;
  logic [8:0] add9;
  logic [4:0] addh;
  logic [8:0] sub9;
  logic [4:0] subh;
  logic [7:0] bit_mask;
  logic       z, n, h, c;

  alu_8_shift u_shift (
    .a_i      (bus.regA),
    .cin_i    (bus.flagsIn[FLAG_C]),
    .opcode_i (bus.opcode),
    .result_o (sh_res),
    .cout_o   (sh_c)
  );

  // Arithmetic is computed one bit wider so carry/borrow out of bit 7 and bit 3 fall out of the top bit
  always_comb begin
    use_c    = (bus.opcode == OP_ADC || bus.opcode == OP_SBC) ? bus.flagsIn[FLAG_C] : 1'b0;
    add9     = {1'b0, bus.regA} + {1'b0, bus.regB} + {8'd0, use_c};
    addh     = {1'b0, bus.regA[3:0]} + {1'b0, bus.regB[3:0]} + {4'd0, use_c};
    sub9     = {1'b0, bus.regA} - {1'b0, bus.regB} - {8'd0, use_c};
    subh     = {1'b0, bus.regA[3:0]} - {1'b0, bus.regB[3:0]} - {4'd0, use_c};
    bit_mask = 8'h01 << bus.regB[2:0];
  end

  // Result and flag select; default is pass-through of A and the upper flags, which also covers 0x17-0x1F
  always_comb begin
    res_d = bus.regA;
    z     = bus.flagsIn[FLAG_Z];
    n     = bus.flagsIn[FLAG_N];
    h     = bus.flagsIn[FLAG_H];
    c     = bus.flagsIn[FLAG_C];
    case (bus.opcode)
      OP_ADD, OP_ADC: begin
        res_d = add9[7:0];
        z = (add9[7:0] == 8'h00); n = 1'b0; h = addh[4]; c = add9[8];
      end
      OP_SUB, OP_SBC: begin
        res_d = sub9[7:0];
        z = (sub9[7:0] == 8'h00); n = 1'b1; h = subh[4]; c = sub9[8];
      end
      OP_CP: begin
        res_d = bus.regA;
        z = (sub9[7:0] == 8'h00); n = 1'b1; h = subh[4]; c = sub9[8];
      end
      OP_AND: begin
        res_d = bus.regA & bus.regB;
        z = (res_d == 8'h00); n = 1'b0; h = 1'b1; c = 1'b0;
      end
      OP_OR: begin
        res_d = bus.regA | bus.regB;
        z = (res_d == 8'h00); n = 1'b0; h = 1'b0; c = 1'b0;
      end
      OP_XOR: begin
        res_d = bus.regA ^ bus.regB;
        z = (res_d == 8'h00); n = 1'b0; h = 1'b0; c = 1'b0;
      end
      OP_RL, OP_RR, OP_RLC, OP_RRC, OP_SLA, OP_SRA, OP_SRL, OP_SWAP: begin
        res_d = sh_res;
        z = (sh_res == 8'h00); n = 1'b0; h = 1'b0; c = sh_c;
      end
      OP_RLA, OP_RRA, OP_RLCA, OP_RRCA: begin
        res_d = sh_res;
        z = 1'b0; n = 1'b0; h = 1'b0; c = sh_c;
      end
      OP_BIT: begin
        res_d = bus.regA;
        z = ~|(bus.regA & bit_mask); n = 1'b0; h = 1'b1;
      end
      OP_RES: res_d = bus.regA & ~bit_mask;
      OP_SET: res_d = bus.regA | bit_mask;
      default: res_d = bus.regA;
    endcase
    flags_d = {z, n, h, c, 4'b0000};
  end

  wire unused_flags_lo = &{1'b0, bus.flagsIn[3:0]};

`ifdef ALU8_OUT_REG_EN
  logic [7:0] res_q;
  logic [7:0] flags_q;

  // Output register; reset wins over the result being computed this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= 8'h00;
      flags_q <= 8'h00;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.res      = res_q;
  assign bus.flagsOut = flags_q;
`else
  wire unused_clk_rst = &{1'b0, clk, rst};

  assign bus.res      = res_d;
  assign bus.flagsOut = flags_d;
`endif

endmodule

// File: tb/tb_alu_8.sv
// tb/tb_alu_8.sv - scoreboard bench for alu_8 with hand-computed vectors (handles ALU8_OUT_REG_EN builds)
module tb_alu_8;
  import alu_8_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic [7:0] flags;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drv_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_8_if bus();

  alu_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input string name, input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] f, input logic r,
                       input logic [7:0] eres, input logic [7:0] eflags);
    exp_t e;
    @(negedge clk);
    bus.opcode  = op;
    bus.regA    = a;
    bus.regB    = b;
    bus.flagsIn = f;
    rst         = r;
    e.res   = eres;
    e.flags = eflags;
    e.name  = name;
`ifdef ALU8_OUT_REG_EN
    if (r) begin
      e.res   = 8'h00;
      e.flags = 8'h00;
    end
`endif
    exp_q.push_back(e);
    drv_valid = 1'b1;
  endtask

  // Monitor: inputs change at negedge, so results are stable just after posedge in both builds
  always @(posedge clk) begin : monitor
    logic v;
    exp_t e;
    v = drv_valid;
    #1;
    if (v) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty res=%02h flags=%02h required=none", bus.res, bus.flagsOut);
      end else begin
        e = exp_q.pop_front();
        if (bus.res !== e.res || bus.flagsOut !== e.flags) begin
          errors++;
          $display("FAIL %s res=%02h flags=%02h required res=%02h flags=%02h",
                   e.name, bus.res, bus.flagsOut, e.res, e.flags);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.opcode  = OP_ADD;
    bus.regA    = 8'h00;
    bus.regB    = 8'h00;
    bus.flagsIn = 8'h00;
    repeat (2) @(posedge clk);
    issue("rst_first",  OP_ADD,  8'h12, 8'h34, 8'h00, 1'b1, 8'h46, 8'h00);
    issue("adc_half",   OP_ADC,  8'h0F, 8'h00, 8'h10, 1'b0, 8'h10, 8'h20);
    issue("add_wrap",   OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b0, 8'h00, 8'hB0);
    issue("add_h",      OP_ADD,  8'h08, 8'h08, 8'h00, 1'b0, 8'h10, 8'h20);
    issue("adc_noc",    OP_ADC,  8'h01, 8'h01, 8'hE0, 1'b0, 8'h02, 8'h00);
    issue("sbc_zero",   OP_SBC,  8'h10, 8'h0F, 8'h10, 1'b0, 8'h00, 8'hE0);
    issue("sub_h",      OP_SUB,  8'h3E, 8'h0F, 8'h00, 1'b0, 8'h2F, 8'h60);
    issue("cp_borrow",  OP_CP,   8'h05, 8'h06, 8'h00, 1'b0, 8'h05, 8'h70);
    issue("and",        OP_AND,  8'h0F, 8'hF1, 8'h00, 1'b0, 8'h01, 8'h20);
    issue("or_zero",    OP_OR,   8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h80);
    issue("xor_zero",   OP_XOR,  8'hAA, 8'hAA, 8'h10, 1'b0, 8'h00, 8'h80);
    issue("rl",         OP_RL,   8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 8'h90);
    issue("rla",        OP_RLA,  8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 8'h10);
    issue("rr_cin",     OP_RR,   8'h01, 8'h00, 8'h10, 1'b0, 8'h80, 8'h10);
    issue("rrc",        OP_RRC,  8'h01, 8'h00, 8'h00, 1'b0, 8'h80, 8'h10);
    issue("rlc",        OP_RLC,  8'h80, 8'h00, 8'h00, 1'b0, 8'h01, 8'h10);
    issue("rrca_z0",    OP_RRCA, 8'h00, 8'h00, 8'h10, 1'b0, 8'h00, 8'h00);
    issue("sla",        OP_SLA,  8'h41, 8'h00, 8'h10, 1'b0, 8'h82, 8'h00);
    issue("sra",        OP_SRA,  8'h81, 8'h00, 8'h00, 1'b0, 8'hC0, 8'h10);
    issue("srl_zero",   OP_SRL,  8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h90);
    issue("swap_zero",  OP_SWAP, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h80);
    issue("swap",       OP_SWAP, 8'h1E, 8'h00, 8'h10, 1'b0, 8'hE1, 8'h00);
    issue("bit3_set",   OP_BIT,  8'h08, 8'h03, 8'h10, 1'b0, 8'h08, 8'h30);
    issue("bit2_clr",   OP_BIT,  8'h08, 8'h02, 8'h10, 1'b0, 8'h08, 8'hB0);
    issue("bit_hib",    OP_BIT,  8'h80, 8'hFF, 8'h00, 1'b0, 8'h80, 8'h20);
    issue("set7",       OP_SET,  8'h00, 8'h07, 8'hF0, 1'b0, 8'h80, 8'hF0);
    issue("res0",       OP_RES,  8'hFF, 8'h00, 8'h00, 1'b0, 8'hFE, 8'h00);
    issue("res_hib",    OP_RES,  8'h01, 8'hF8, 8'h40, 1'b0, 8'h00, 8'h40);
    issue("op17",       5'h17,   8'h5A, 8'h33, 8'hFF, 1'b0, 8'h5A, 8'hF0);
    issue("op1f",       5'h1F,   8'h00, 8'hFF, 8'h0F, 1'b0, 8'h00, 8'h00);
    issue("rst_mid",    OP_ADD,  8'h01, 8'h01, 8'h00, 1'b1, 8'h02, 8'h00);
    issue("after_rst",  OP_ADD,  8'h01, 8'h02, 8'h00, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    drv_valid = 1'b0;
    rst       = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
